// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder/subtractor built on one FA2 full-adder cell

module fa2 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c;
    assign c_out = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             ovf_r;
    logic             fa_s;
    logic             fa_co;

    fa2 u_fa2 (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry),
        .s     (fa_s),
        .c_out (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B at load and force the initial carry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            res   <= '0;
            cnt   <= '0;
            carry <= sub ? 1'b1 : c_in;
            ovf_r <= 1'b0;
        end else if (state == RUN) begin
            a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
            res   <= {fa_s, res[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
            carry <= fa_co;
            // On the MSB step the carry register holds the carry into the MSB.
            if (cnt == LAST) begin
                ovf_r <= carry ^ fa_co;
            end
        end
    end

    assign sum   = res;
    assign c_out = carry;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed scoreboard bench for serial_adder

module tb_serial_adder;
    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       c_in;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       c_out;
    logic       ovf;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y,
                                   input logic ci, input logic s);
        logic [7:0] yy;
        logic [8:0] tot;
        exp_t       r;
        yy  = s ? ~y : y;
        tot = {1'b0, x} + {1'b0, yy} + {8'd0, (s ? 1'b1 : ci)};
        r.s = tot[7:0];
        r.c = tot[8];
        r.v = (x[7] == yy[7]) && (tot[7] != x[7]);
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns right after the accepting edge.
    task automatic launch(input logic [7:0] x, input logic [7:0] y,
                          input logic ci, input logic s);
        a        = x;
        b        = y;
        c_in     = ci;
        sub      = s;
        in_valid = 1'b1;
        chk("accept_in_ready", {31'd0, in_ready}, 32'd1);
        sb.push_back(model(x, y, ci, s));
        @(posedge clk);
    endtask

    task automatic collect(input logic check_lat, input int hold, input logic toggle);
        int   lat;
        exp_t e;
        @(negedge clk);
        if (!toggle) in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (toggle) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk("out_valid_rise", {31'd0, out_valid}, 32'd1);
        if (check_lat) chk("latency_edges", lat, 32'd9);
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            chk("hold_sum", {24'd0, sum}, {24'd0, e.s});
            chk("hold_c_out", {31'd0, c_out}, {31'd0, e.c});
            chk("hold_ovf", {31'd0, ovf}, {31'd0, e.v});
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            if (toggle) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            @(negedge clk);
        end
        chk("sum", {24'd0, sum}, {24'd0, e.s});
        chk("c_out", {31'd0, c_out}, {31'd0, e.c});
        chk("ovf", {31'd0, ovf}, {31'd0, e.v});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        sub       = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_c_out", {31'd0, c_out}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        launch(8'h35, 8'h4A, 1'b0, 1'b0); collect(1'b1, 0, 1'b0);
        launch(8'hFF, 8'h01, 1'b0, 1'b0); collect(1'b1, 0, 1'b0);
        launch(8'hFF, 8'h00, 1'b1, 1'b0); collect(1'b0, 0, 1'b0);
        launch(8'h7F, 8'h01, 1'b0, 1'b0); collect(1'b0, 0, 1'b0);
        launch(8'h80, 8'h01, 1'b0, 1'b1); collect(1'b0, 0, 1'b0);
        launch(8'h10, 8'h20, 1'b1, 1'b1); collect(1'b0, 0, 1'b0);

        // Backpressure with in_valid held high and operands churning.
        launch(8'hC3, 8'h5A, 1'b0, 1'b1); collect(1'b1, 5, 1'b1);
        launch(8'hA5, 8'h96, 1'b1, 1'b0); collect(1'b1, 0, 1'b0);

        // Abort in the third RUN cycle.
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("abort_sum", {24'd0, sum}, 32'd0);
        chk("abort_c_out", {31'd0, c_out}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort_no_out_valid", {31'd0, out_valid}, 32'd0);
            chk("abort_idle_ready", {31'd0, in_ready}, 32'd1);
        end
        launch(8'h01, 8'h01, 1'b0, 1'b0); collect(1'b1, 0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            launch(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            collect(1'b1, int'($urandom_range(0, 2)), 1'b0);
        end

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
